// File: rtl/router_pkg.sv
// Shared router definitions: flit field layout, stored word width and opcodes.
package router_pkg;

   localparam int F_PAYLOAD_POS  = 0;
   localparam int F_PAYLOAD_W    = 32;
   localparam int F_OP_POS       = 32;
   localparam int F_OP_W         = 4;
   localparam int F_ALGTYPE_POS  = 36;
   localparam int F_ALGTYPE_W    = 3;
   localparam int F_TAG_POS      = 39;
   localparam int F_TAG_W        = 8;
   localparam int F_CTX_POS      = 47;
   localparam int F_CTX_W        = 6;
   localparam int F_RANK_POS     = 53;
   localparam int F_RANK_W       = 10;
   localparam int F_SRC_XYZ_POS  = 63;
   localparam int F_DST_XYZ_POS  = 72;
   localparam int F_XYZ_W        = 9;
   localparam int F_VALID_POS    = 81;
   localparam int F_CHILDREN_POS = 82;
   localparam int F_CHILDREN_W   = 3;

   localparam int FLIT_W = F_CHILDREN_POS + F_CHILDREN_W;

   typedef enum logic [F_OP_W-1:0] {
      OP_NOP   = 4'h0,
      OP_SUM   = 4'h1,
      OP_MAX   = 4'h2,
      OP_MIN   = 4'h3,
      OP_AND   = 4'h4,
      OP_OR    = 4'h5,
      OP_XOR   = 4'h6,
      OP_BCAST = 4'h7
   } alg_op_e;

endpackage

// File: rtl/vc_fifo_bank.sv
// Single-channel circular queue: storage array, read/write pointers and occupancy.
// The caller qualifies i_push/i_pop; this bank never checks for overflow itself.
module vc_fifo_bank #(
   parameter int FLIT_W   = 85,
   parameter int LG_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [FLIT_W-1:0] i_wr_data,
   output logic [FLIT_W-1:0] o_rd_word,
   output logic [LG_DEPTH:0] o_count,
   output logic              o_full,
   output logic              o_empty
);

   localparam int DEPTH = 2 ** LG_DEPTH;

   logic [FLIT_W-1:0]   r_mem [DEPTH];
   logic [LG_DEPTH-1:0] r_wr_ptr;
   logic [LG_DEPTH-1:0] r_rd_ptr;
   logic [LG_DEPTH:0]   r_count;

   // NOTE: the array has no reset; occupancy gating keeps stale words from ever being read.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_word = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign o_full    = (r_count == (LG_DEPTH+1)'(DEPTH));
   assign o_empty   = (r_count == '0);

endmodule

// File: rtl/vc_flit_fifo.sv
// Multi-VC flit buffer: NUM_VC queues behind one write and one read port, sticky errors.
// Optional macro FIFO_BYPASS_EN forwards a same-cycle write straight to an empty channel's read.
module vc_flit_fifo #(
   parameter int FLIT_W    = router_pkg::FLIT_W,
   parameter int VALID_POS = router_pkg::F_VALID_POS,
   parameter int LG_DEPTH  = 4,
   parameter int NUM_VC    = 2,
   parameter int LG_VC     = 1,
   parameter int AFULL_TH  = (2 ** LG_DEPTH) - 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic [LG_VC-1:0]               wr_vc,
   input  logic [FLIT_W-1:0]              wr_data,
   input  logic                           rd_en,
   input  logic [LG_VC-1:0]               rd_vc,
   output logic [FLIT_W-1:0]              rd_data,
   output logic                           rd_valid,
   output logic [NUM_VC-1:0]              empty,
   output logic [NUM_VC-1:0]              full,
   output logic [NUM_VC-1:0]              afull,
   output logic [NUM_VC*(LG_DEPTH+1)-1:0] count,
   output logic                           ovf_err,
   output logic                           unf_err
);

   localparam int CW = LG_DEPTH + 1;

   logic [NUM_VC-1:0] w_wr_sel;
   logic [NUM_VC-1:0] w_rd_sel;
   logic [NUM_VC-1:0] w_push;
   logic [NUM_VC-1:0] w_pop;
   logic [NUM_VC-1:0] w_bypass;
   logic [FLIT_W-1:0] w_bank_word [NUM_VC];
   logic [FLIT_W-1:0] w_pop_word;
   logic              w_wr_valid;
   logic              w_wr_in_range;
   logic              w_rd_in_range;
   logic              w_ovf;
   logic              w_unf;

   logic [FLIT_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_ovf_err;
   logic              r_unf_err;

   assign w_wr_valid    = wr_en & wr_data[VALID_POS];
   assign w_wr_in_range = (32'(wr_vc) < NUM_VC);
   assign w_rd_in_range = (32'(rd_vc) < NUM_VC);

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      logic [CW-1:0] w_cnt;

      assign w_wr_sel[v] = w_wr_valid & (32'(wr_vc) == v);
      assign w_rd_sel[v] = rd_en & (32'(rd_vc) == v);
      assign w_pop[v]    = w_rd_sel[v] & ~empty[v];
`ifdef FIFO_BYPASS_EN
      assign w_bypass[v] = w_rd_sel[v] & empty[v] & w_wr_sel[v];
`else
      assign w_bypass[v] = 1'b0;
`endif
      // A full channel still takes a write when the same channel is popped this cycle.
      assign w_push[v]   = w_wr_sel[v] & (~full[v] | w_pop[v]) & ~w_bypass[v];

      vc_fifo_bank #(
         .FLIT_W   (FLIT_W),
         .LG_DEPTH (LG_DEPTH)
      ) u_bank (
         .clk       (clk),
         .rst       (rst),
         .i_push    (w_push[v]),
         .i_pop     (w_pop[v]),
         .i_wr_data (wr_data),
         .o_rd_word (w_bank_word[v]),
         .o_count   (w_cnt),
         .o_full    (full[v]),
         .o_empty   (empty[v])
      );

      assign count[v*CW +: CW] = w_cnt;
      assign afull[v]          = (32'(w_cnt) >= AFULL_TH);
   end

   assign w_ovf = w_wr_valid & (~w_wr_in_range | (|(w_wr_sel & ~w_push & ~w_bypass)));
   assign w_unf = rd_en & (~w_rd_in_range | (|(w_rd_sel & empty & ~w_bypass)));

   // NOTE: default first so no path through this block leaves w_pop_word unassigned (no latch).
   always_comb begin
      w_pop_word = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (w_pop[v]) w_pop_word = w_bank_word[v];
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_ovf_err  <= 1'b0;
         r_unf_err  <= 1'b0;
      end else begin
         r_rd_valid <= (|w_pop) | (|w_bypass);
         if (|w_pop)         r_rd_data <= w_pop_word;
         else if (|w_bypass) r_rd_data <= wr_data;
         r_ovf_err  <= r_ovf_err | w_ovf;
         r_unf_err  <= r_unf_err | w_unf;
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign ovf_err  = r_ovf_err;
   assign unf_err  = r_unf_err;

endmodule

// File: tb/tb_vc_flit_fifo.sv
// Directed and short random bench for vc_flit_fifo with a per-VC queue model and read scoreboard.
// Handles both builds: with and without FIFO_BYPASS_EN.
module tb_vc_flit_fifo;

   localparam int FW    = 85;
   localparam int VPOS  = 81;
   localparam int LGD   = 4;
   localparam int DEPTH = 16;
   localparam int NVC   = 2;
   localparam int LGVC  = 1;
   localparam int CW    = LGD + 1;
`ifdef FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [LGVC-1:0]   wr_vc;
   logic [FW-1:0]     wr_data;
   logic              rd_en;
   logic [LGVC-1:0]   rd_vc;
   logic [FW-1:0]     rd_data;
   logic              rd_valid;
   logic [NVC-1:0]    empty;
   logic [NVC-1:0]    full;
   logic [NVC-1:0]    afull;
   logic [NVC*CW-1:0] count;
   logic              ovf_err;
   logic              unf_err;

   vc_flit_fifo #(
      .FLIT_W    (FW),
      .VALID_POS (VPOS),
      .LG_DEPTH  (LGD),
      .NUM_VC    (NVC),
      .LG_VC     (LGVC),
      .AFULL_TH  (DEPTH - 2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_vc    (wr_vc),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_vc    (rd_vc),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .afull    (afull),
      .count    (count),
      .ovf_err  (ovf_err),
      .unf_err  (unf_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [FW-1:0] mq [NVC][$];
   logic [FW-1:0] exp_q [$];
   logic [FW-1:0] m_last;
   bit            m_ovf;
   bit            m_unf;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [FW-1:0] mk(input int n, input bit vld);
      logic [FW-1:0] w;
      logic [31:0]   h;
      h = 32'(n) * 32'h9E37_79B1 + 32'h0000_1234;
      w = '0;
      w[31:0]  = h;
      w[46:39] = 8'(n);
      w[84:82] = h[31:29];
      w[VPOS]  = vld;
      return w;
   endfunction

   task automatic clear_model();
      for (int v = 0; v < NVC; v++) mq[v].delete();
      exp_q.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic check_flags();
      logic [NVC*CW-1:0] e_cnt;
      logic [NVC-1:0]    e_empty, e_full, e_afull;
      for (int v = 0; v < NVC; v++) begin
         e_cnt[v*CW +: CW] = CW'(mq[v].size());
         e_empty[v]        = (mq[v].size() == 0);
         e_full[v]         = (mq[v].size() == DEPTH);
         e_afull[v]        = (mq[v].size() >= DEPTH - 2);
      end
      check("count", 128'(count), 128'(e_cnt));
      check("empty", 128'(empty), 128'(e_empty));
      check("full", 128'(full), 128'(e_full));
      check("afull", 128'(afull), 128'(e_afull));
      check("ovf_err", 128'(ovf_err), 128'(m_ovf));
      check("unf_err", 128'(unf_err), 128'(m_unf));
   endtask

   // Apply the current inputs for one clock edge, update the model and compare at edge+1.
   task automatic cycle();
      bit rd_acc, wr_acc, byp, m_valid;
      int wv, rv;
      wv = int'(wr_vc);
      rv = int'(rd_vc);
      rd_acc = 1'b0;
      wr_acc = 1'b0;
      byp    = 1'b0;
      if (rd_en) begin
         if (rv < NVC && mq[rv].size() > 0) rd_acc = 1'b1;
         else if (BYP && rv < NVC && wr_en && wr_data[VPOS] && wv == rv) byp = 1'b1;
         else m_unf = 1'b1;
      end
      if (wr_en && wr_data[VPOS] && !byp) begin
         if (wv >= NVC) m_ovf = 1'b1;
         else if (mq[wv].size() < DEPTH || (rd_acc && rv == wv)) wr_acc = 1'b1;
         else m_ovf = 1'b1;
      end
      if (rd_acc) exp_q.push_back(mq[rv].pop_front());
      if (byp)    exp_q.push_back(wr_data);
      if (wr_acc) mq[wv].push_back(wr_data);
      m_valid = rd_acc | byp;

      @(posedge clk);
      #1;
      check("rd_valid", 128'(rd_valid), 128'(m_valid));
      if (m_valid) m_last = exp_q.pop_front();
      check("rd_data", 128'(rd_data), 128'(m_last));
      check_flags();
   endtask

   task automatic drive(input bit we, input int wv, input logic [FW-1:0] wd,
                        input bit re, input int rv);
      wr_en   = we;
      wr_vc   = LGVC'(wv);
      wr_data = wd;
      rd_en   = re;
      rd_vc   = LGVC'(rv);
      cycle();
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear_model();
      check("rst_rd_data", 128'(rd_data), 128'(0));
      check("rst_rd_valid", 128'(rd_valid), 128'(0));
      check_flags();
      rst = 1'b1;
   endtask

   initial begin
      rst     = 1'b0;
      wr_en   = 1'b0;
      wr_vc   = '0;
      wr_data = '0;
      rd_en   = 1'b0;
      rd_vc   = '0;
      clear_model();
      do_reset();

      // Interleaved channels: A,B on vc0 and C on vc1, read back as C, A, B.
      drive(1, 0, mk(1, 1), 0, 0);
      drive(1, 0, mk(2, 1), 0, 0);
      drive(1, 1, mk(3, 1), 0, 0);
      drive(0, 0, '0, 1, 1);
      drive(0, 0, '0, 1, 0);
      drive(0, 0, '0, 1, 0);
      drive(0, 0, '0, 0, 0);

      // Word with valid bit clear is dropped without any error.
      drive(1, 0, mk(4, 0), 0, 0);
      drive(1, 1, mk(5, 0), 0, 0);

      // Read of empty vc1 sets unf_err and leaves rd_data alone.
      drive(0, 0, '0, 1, 1);
      drive(0, 0, '0, 0, 0);

      // Fill vc0, overflow it, then simultaneous write/read across pointer wrap, then drain.
      for (int i = 0; i < DEPTH; i++) drive(1, 0, mk(10 + i, 1), 0, 0);
      drive(1, 0, mk(99, 1), 0, 0);
      for (int i = 0; i < 20; i++) drive(1, 0, mk(40 + i, 1), 1, 0);
      for (int i = 0; i < DEPTH; i++) drive(0, 0, '0, 1, 0);
      drive(0, 0, '0, 0, 0);

      // Same-cycle write and read on an empty channel, with sticky flags cleared first.
      do_reset();
      drive(1, 0, mk(200, 1), 1, 0);
      drive(0, 0, '0, 1, 0);
      drive(0, 0, '0, 0, 0);

      // Independent traffic on both channels.
      do_reset();
      for (int i = 0; i < 80; i++) begin
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 1)),
               mk(300 + i, $urandom_range(0, 7) != 0),
               $urandom_range(0, 2) == 0, int'($urandom_range(0, 1)));
      end

      // Asynchronous reset with words queued clears state before the next edge.
      do_reset();
      for (int i = 0; i < 5; i++) drive(1, 0, mk(500 + i, 1), 0, 0);
      drive(0, 0, '0, 1, 0);
      #2;
      rst = 1'b0;
      #1;
      clear_model();
      check("async_rd_valid", 128'(rd_valid), 128'(0));
      check("async_rd_data", 128'(rd_data), 128'(0));
      check_flags();
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(0, 0, '0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
